// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration chain loader.
// The CRC state and constants are only exercised when CONFIG_LOADER_CRC_EN is defined.
package config_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int unsigned CRC_WIDTH = 8;
  localparam logic [CRC_WIDTH-1:0] CRC8_POLY = 8'h07;
  localparam logic [CRC_WIDTH-1:0] CRC8_INIT = 8'h00;

  // Bits needed to hold every value from 0 up to and including max_value.
  function automatic int unsigned cnt_width(input int unsigned max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/config_loader_crc8.sv
// Serial MSB-first CRC-8 accumulator (poly 0x07, init 0x00), one bit per enabled cycle.
module config_crc8_serial
  import config_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 bit_in,
  output logic [CRC_WIDTH-1:0] crc
);

  logic [CRC_WIDTH-1:0] crc_q;
  logic [CRC_WIDTH-1:0] crc_d;
  logic                 feedback;

  // Clear wins over a same-cycle update so a new load starts from the init value.
  always_comb begin
    crc_d    = crc_q;
    feedback = crc_q[CRC_WIDTH-1] ^ bit_in;
    if (clear) begin
      crc_d = CRC8_INIT;
    end else if (enable) begin
      crc_d = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (feedback ? CRC8_POLY : CRC_WIDTH'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC8_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/config_chain_loader.sv
// Streams bitstream words MSB-first onto the tile configuration chain, one enable per bit.
// Define CONFIG_LOADER_CRC_EN to add a trailing CRC-8 check word and a live error flag.
module config_chain_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned CHAIN_LENGTH = 24,
  parameter int unsigned COUNT_WIDTH  = cnt_width(CHAIN_LENGTH)
) (
  input  logic                  config_clock,
  input  logic                  config_reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  chain_data,
  output logic                  chain_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned WBIT_WIDTH = cnt_width(WORD_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] CHAIN_LAST = COUNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [WBIT_WIDTH-1:0]  WORD_LAST  = WBIT_WIDTH'(WORD_WIDTH - 1);
`ifdef CONFIG_LOADER_CRC_EN
  localparam state_e FINAL_STATE = CHECK;
`else
  localparam state_e FINAL_STATE = DONE;
`endif

  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   buf_q, buf_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WBIT_WIDTH-1:0]   wbit_q, wbit_d;
  logic                    s_ready_q, s_ready_d;
  logic                    chain_data_q, chain_data_d;
  logic                    chain_enable_q, chain_enable_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

`ifdef CONFIG_LOADER_CRC_EN
  logic                    error_q, error_d;
  logic                    crc_clear_c;
  logic [CRC_WIDTH-1:0]    crc;

  // Runs over exactly the bits presented to the chain head.
  config_crc8_serial u_crc (
    .clk    (config_clock),
    .rst    (config_reset),
    .clear  (crc_clear_c),
    .enable (chain_enable_q),
    .bit_in (chain_data_q),
    .crc    (crc)
  );
`endif

  // Next-state logic; every registered output is derived from the state being entered.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    wbit_d       = wbit_q;
    chain_data_d = 1'b0;
    done_d       = done_q;
`ifdef CONFIG_LOADER_CRC_EN
    error_d      = error_q;
    crc_clear_c  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
          error_d     = 1'b0;
          crc_clear_c = 1'b1;
`endif
        end
      end
      LOAD: begin
        if (s_valid) begin
          state_d      = SHIFT;
          buf_d        = s_data;
          wbit_d       = '0;
          chain_data_d = s_data[WORD_WIDTH-1];
        end
      end
      SHIFT: begin
        buf_d  = buf_q << 1;
        cnt_d  = cnt_q + COUNT_WIDTH'(1);
        wbit_d = wbit_q + WBIT_WIDTH'(1);
        // Chain end beats word end, which drops the unused low bits of a partial last word.
        if (cnt_q >= CHAIN_LAST) begin
          state_d = FINAL_STATE;
          buf_d   = '0;
        end else if (wbit_q == WORD_LAST) begin
          state_d = LOAD;
        end else begin
          chain_data_d = buf_q[WORD_WIDTH-2];
        end
      end
`ifdef CONFIG_LOADER_CRC_EN
      CHECK: begin
        if (s_valid) begin
          state_d = DONE;
          error_d = (s_data[CRC_WIDTH-1:0] != crc);
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == DONE) begin
      done_d = 1'b1;
    end
    s_ready_d      = (state_d == LOAD) || (state_d == CHECK);
    chain_enable_d = (state_d == SHIFT);
    busy_d         = s_ready_d || chain_enable_d;
  end

  always_ff @(posedge config_clock) begin
    if (config_reset) begin
      state_q        <= IDLE;
      buf_q          <= '0;
      cnt_q          <= '0;
      wbit_q         <= '0;
      s_ready_q      <= 1'b0;
      chain_data_q   <= 1'b0;
      chain_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
      error_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      buf_q          <= buf_d;
      cnt_q          <= cnt_d;
      wbit_q         <= wbit_d;
      s_ready_q      <= s_ready_d;
      chain_data_q   <= chain_data_d;
      chain_enable_q <= chain_enable_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef CONFIG_LOADER_CRC_EN
      error_q        <= error_d;
`endif
    end
  end

  assign s_ready      = s_ready_q;
  assign chain_data   = chain_data_q;
  assign chain_enable = chain_enable_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef CONFIG_LOADER_CRC_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: a 24-bit and a 20-bit chain instance, checked
// each cycle against a bitstream/chain model, plus hand-computed end-of-load expectations.
module tb_config_chain_loader;

  localparam int NI = 2;
  localparam int WW = 8;
`ifdef CONFIG_LOADER_CRC_EN
  localparam int NWORDS    = 4;
  localparam int CRC_EXTRA = 1;
`else
  localparam int NWORDS    = 3;
  localparam int CRC_EXTRA = 0;
`endif

  logic              clk;
  logic              rst;
  logic [NI-1:0]     start;
  logic [WW-1:0]     s_data [NI];
  logic [NI-1:0]     s_valid, s_ready, chain_data, chain_enable, busy, done, error;

  // Stimulus/model state shared between the main thread and the per-cycle checker.
  logic [WW-1:0]     src [NI][4];
  bit   [NI-1:0]     slow;
  int                load_seq [NI];
  int                seen_seq [NI];
  int                widx [NI];
  int                bitn [NI];
  int                first_acc [NI];
  int                done_cyc [NI];
  int                acc_idx [NI];
  logic [WW-1:0]     acc_word [NI];
  bit   [NI-1:0]     acc_q;
  logic [23:0]       chain_q [NI];
  int                cyc;
  bit                go;
  int                n_chk;
  int                n_fail;

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(24)) dut24 (
    .config_clock (clk),           .config_reset (rst),
    .start        (start[0]),      .s_data       (s_data[0]),
    .s_valid      (s_valid[0]),    .s_ready      (s_ready[0]),
    .chain_data   (chain_data[0]), .chain_enable (chain_enable[0]),
    .busy         (busy[0]),       .done         (done[0]),
    .error        (error[0])
  );

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20)) dut20 (
    .config_clock (clk),           .config_reset (rst),
    .start        (start[1]),      .s_data       (s_data[1]),
    .s_valid      (s_valid[1]),    .s_ready      (s_ready[1]),
    .chain_data   (chain_data[1]), .chain_enable (chain_enable[1]),
    .busy         (busy[1]),       .done         (done[1]),
    .error        (error[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int cl_of(input int i);
    return (i == 0) ? 24 : 20;
  endfunction

  // Bit n of the concatenated bitstream, first word first, MSB first.
  function automatic logic exp_bit(input int i, input int n);
    logic [WW-1:0] w;
    w = src[i][n / WW];
    return w[WW - 1 - (n % WW)];
  endfunction

`ifdef CONFIG_LOADER_CRC_EN
  function automatic logic [7:0] crc_model(input int i);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int n = 0; n < cl_of(i); n++) begin
      fb = c[7] ^ exp_bit(i, n);
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  // Per-cycle checker and stream source, sampled on the falling edge.
  initial begin
    s_valid = '0;
    for (int i = 0; i < NI; i++) begin
      s_data[i] = '0; seen_seq[i] = 0; widx[i] = 0; bitn[i] = 0;
      first_acc[i] = -1; done_cyc[i] = -1; acc_idx[i] = 0; acc_word[i] = '0; chain_q[i] = '0;
    end
    acc_q = '0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!go) continue;
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (load_seq[i] != seen_seq[i]) begin
          seen_seq[i] = load_seq[i];
          widx[i] = 0; bitn[i] = 0; first_acc[i] = -1; done_cyc[i] = -1; acc_q[i] = 1'b0;
        end
        if (acc_q[i]) begin
          if (acc_idx[i] < 3) begin
            chk("first_bit_enable", chain_enable[i], 1);
            chk("first_bit_value", chain_data[i], acc_word[i][WW-1]);
          end else begin
            chk("check_word_no_shift", chain_enable[i], 0);
          end
        end
        if (chain_enable[i]) begin
          chk("enable_count_in_range", bitn[i] < cl_of(i), 1);
          if (bitn[i] < cl_of(i)) chk("chain_bit_value", chain_data[i], exp_bit(i, bitn[i]));
          chain_q[i] = {chain_q[i][22:0], chain_data[i]};
          bitn[i]++;
        end
        chk("ready_excl_enable", s_ready[i] & chain_enable[i], 0);
        chk("busy_excl_done", busy[i] & done[i], 0);
        if (busy[i] && !chain_enable[i]) chk("gap_only_in_load", s_ready[i], 1);
        if (done[i] && first_acc[i] >= 0 && done_cyc[i] < 0) done_cyc[i] = cyc;
        if (acc_q[i]) widx[i]++;
        s_valid[i] = (widx[i] < NWORDS) && (!slow[i] || (cyc % 3 == 0));
        s_data[i]  = (widx[i] < NWORDS) ? src[i][widx[i]] : '0;
        acc_q[i]   = s_valid[i] & s_ready[i];
        if (acc_q[i]) begin
          acc_idx[i]  = widx[i];
          acc_word[i] = s_data[i];
          if (first_acc[i] < 0) first_acc[i] = cyc;
        end
      end
    end
  end

  task automatic set_words(input int i, input int crc_word);
    src[i][0] = 8'hA5; src[i][1] = 8'h3C; src[i][2] = 8'hF0;
`ifdef CONFIG_LOADER_CRC_EN
    src[i][3] = (crc_word < 0) ? crc_model(i) : 8'(crc_word);
`else
    src[i][3] = 8'(crc_word);
`endif
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    load_seq[i]++;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // One full load; exp_lat < 0 skips the latency check, crc_word < 0 means model CRC.
  task automatic run_load(input int i, input bit slow_mode, input bit poke, input int crc_word,
                          input logic [23:0] exp_chain, input int exp_lat, input bit exp_err);
    bit got_done;
    bit poked;
    logic [23:0] mask;
    set_words(i, crc_word);
    slow[i] = slow_mode;
    pulse_start(i);
    got_done = 1'b0;
    poked = 1'b0;
    for (int k = 0; k < 600 && !got_done; k++) begin
      if (done[i]) begin
        got_done = 1'b1;
      end else begin
        if (poke && !poked && bitn[i] >= 3) begin
          start[i] = 1'b1;
          poked = 1'b1;
        end else begin
          start[i] = 1'b0;
        end
        @(negedge clk);
      end
    end
    start[i] = 1'b0;
    chk("done_within_budget", got_done, 1);
    @(negedge clk);
    mask = 24'((32'd1 << cl_of(i)) - 1);
    chk("chain_contents", chain_q[i] & mask, exp_chain);
    chk("enable_cycles", bitn[i], cl_of(i));
    chk("done_held", done[i], 1);
    chk("busy_after_done", busy[i], 0);
    chk("error_flag", error[i], exp_err);
    if (exp_lat >= 0) chk("done_latency", done_cyc[i] - first_acc[i], exp_lat);
  endtask

  initial begin
    rst = 1'b1; start = '0; slow = '0; go = 1'b0; n_chk = 0; n_fail = 0;
    for (int i = 0; i < NI; i++) load_seq[i] = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk("reset_outputs", {s_ready[i], chain_data[i], chain_enable[i], busy[i], done[i], error[i]}, 0);
    rst = 1'b0;
    go = 1'b1;

    // Full 24-bit chain with back-to-back words; 0x53 is the hand-computed CRC of A5 3C F0.
    run_load(0, 1'b0, 1'b0, 8'h53, 24'hA53CF0, 27 + CRC_EXTRA, 1'b0);
    // 20-bit chain: only the top nibble of the last word reaches the chain.
    run_load(1, 1'b0, 1'b0, -1, 24'h0A53CF, 23 + CRC_EXTRA, 1'b0);
    // Starved source: valid one cycle in three.
    run_load(0, 1'b1, 1'b0, 8'h53, 24'hA53CF0, -1, 1'b0);
    // Start pulsed mid-shift is ignored.
    run_load(0, 1'b0, 1'b1, 8'h53, 24'hA53CF0, 27 + CRC_EXTRA, 1'b0);

    // Reset after 10 bits aborts the load; done on the other instance is cleared too.
    set_words(0, 8'h53);
    slow[0] = 1'b0;
    pulse_start(0);
    for (int k = 0; k < 200 && bitn[0] < 10; k++) @(negedge clk);
    chk("reached_10_bits", bitn[0] >= 10, 1);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk("midload_reset_outputs", {s_ready[i], chain_data[i], chain_enable[i], busy[i], done[i], error[i]}, 0);
    rst = 1'b0;
    run_load(0, 1'b0, 1'b0, 8'h53, 24'hA53CF0, 27 + CRC_EXTRA, 1'b0);

`ifdef CONFIG_LOADER_CRC_EN
    // Corrupted CRC (bit 0 flipped) flags error but still completes with identical contents.
    run_load(0, 1'b0, 1'b0, 8'h52, 24'hA53CF0, 28, 1'b1);
    run_load(1, 1'b0, 1'b0, -1, 24'h0A53CF, 24, 1'b0);
    run_load(0, 1'b0, 1'b0, 8'h53, 24'hA53CF0, 28, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
